// File: rtl/bambu_slave_port_master.sv
// bambu_slave_port_master: host-side initiator for the accelerator slave memory port,
// plus start/done sequencing with a run-length cycle counter and watchdogs.
module bambu_slave_port_master #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 64,
    parameter int SIZE_W      = 7,
    parameter int MEM_TIMEOUT = 255,
    parameter int RUN_TIMEOUT = 200000000,
    parameter int CYC_W       = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [SIZE_W-1:0]     cmd_size,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  run_valid,
    output logic                  run_ready,
    output logic                  run_done,
    output logic [CYC_W-1:0]      run_cycles,
    output logic                  run_err,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);
    typedef enum logic [2:0] {IDLE, MEM_REQ, RSP, RUN_START, RUN_WAIT, RUN_DONE} state_t;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d, wr_q, wr_d, err_q, err_d, rerr_q, rerr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, rd_mask;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                legal, mem, unused_ok;

    assign legal = cmd_size == SIZE_W'(8) || cmd_size == SIZE_W'(16) ||
                   cmd_size == SIZE_W'(32) || cmd_size == SIZE_W'(64);
    assign rd_mask = size_q == SIZE_W'(8)  ? DATA_W'(8'hFF) :
                     size_q == SIZE_W'(16) ? DATA_W'(16'hFFFF) :
                     size_q == SIZE_W'(32) ? DATA_W'(32'hFFFF_FFFF) : '1;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wait_d  = wait_q;
        cyc_d   = cyc_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (rdy_q && cmd_valid) begin
                    rdata_d = '0;
                    err_d   = !legal;
                    wait_d  = '0;
                    state_d = legal ? MEM_REQ : RSP;
                    if (legal) begin
                        wr_d    = cmd_write;
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        size_d  = cmd_size;
                    end
                end else if (rdy_q && run_valid) begin
                    state_d = RUN_START;
                end
            end
            MEM_REQ: begin
                wait_d = wait_q + 1'b1;
                // DataRdy wins over a same-cycle timeout
                if (Sout_DataRdy[0]) begin
                    rdata_d = wr_q ? '0 : Sout_Rdata_ram[DATA_W-1:0] & rd_mask;
                    state_d = RSP;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: state_d = IDLE;
            RUN_START: begin
                rerr_d  = 1'b0;
                cyc_d   = done_port ? CYC_W'(1) : '0;
                state_d = done_port ? RUN_DONE : RUN_WAIT;
            end
            RUN_WAIT: begin
                cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
                if (done_port) begin
                    state_d = RUN_DONE;
                end else if (cyc_q == CYC_W'(RUN_TIMEOUT - 1)) begin
                    rerr_d  = 1'b1;
                    state_d = RUN_DONE;
                end
            end
            RUN_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            cyc_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            rerr_q  <= rerr_d;
        end
    end

    assign mem             = state_q == MEM_REQ;
    assign cmd_ready       = rdy_q;
    assign run_ready       = rdy_q;
    assign rsp_valid       = state_q == RSP;
    assign rsp_rdata       = rsp_valid ? rdata_q : '0;
    assign rsp_err         = rsp_valid & err_q;
    assign start_port      = state_q == RUN_START;
    assign run_done        = state_q == RUN_DONE;
    assign run_err         = run_done & rerr_q;
    assign run_cycles      = cyc_q;
    assign S_oe_ram        = {1'b0, mem & ~wr_q};
    assign S_we_ram        = {1'b0, mem & wr_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, mem ? addr_q : {ADDR_W{1'b0}}};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, mem ? wdata_q : {DATA_W{1'b0}}};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, mem ? size_q : {SIZE_W{1'b0}}};
    assign unused_ok       = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};
endmodule

// File: tb/tb_bambu_slave_port_master.sv
// tb_bambu_slave_port_master: directed checks of memory commands, runs, timeouts and reset.
module tb_bambu_slave_port_master;
    localparam int AW = 9, DW = 64, SW = 7, CW = 32;

    logic clock = 1'b0, reset = 1'b0;
    logic cmd_valid = 0, cmd_write = 0, run_valid = 0, done_port = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_size = '0;
    logic [2*DW-1:0] Sout_Rdata_ram = '0;
    logic [1:0] Sout_DataRdy = '0;
    logic cmd_ready, rsp_valid, rsp_err, run_ready, run_done, run_err, start_port;
    logic [DW-1:0] rsp_rdata;
    logic [CW-1:0] run_cycles;
    logic [1:0] S_oe_ram, S_we_ram;
    logic [2*AW-1:0] S_addr_ram;
    logic [2*DW-1:0] S_Wdata_ram;
    logic [2*SW-1:0] S_data_ram_size;
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    bambu_slave_port_master #(.RUN_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .run_valid(run_valid), .run_ready(run_ready), .run_done(run_done),
        .run_cycles(run_cycles), .run_err(run_err),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    // Issues one command and acts as the slave; rdy_at = MEM_REQ cycle raising DataRdy (0 = never).
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [SW-1:0] sz, input int rdy_at, input logic [DW-1:0] srd,
                          output int en, output int lat, output int pulses, output logic err,
                          output logic [DW-1:0] rd, output logic [AW-1:0] a_seen,
                          output logic [DW-1:0] wd_seen, output logic [SW-1:0] sz_seen,
                          output logic bad);
        int n;
        logic act;
        en = 0; lat = 0; pulses = 0; err = 0; rd = '0; a_seen = '0; wd_seen = '0; sz_seen = '0; bad = 0;
        n = (rdy_at > 0 ? rdy_at : 255) + 4;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_size = sz;
        @(negedge clock);
        cmd_valid = 0;
        for (int k = 1; k <= n; k++) begin
            act = w ? S_we_ram[0] : S_oe_ram[0];
            if (act) begin
                en++;
                if (en == 1) begin
                    a_seen = S_addr_ram[AW-1:0]; wd_seen = S_Wdata_ram[DW-1:0]; sz_seen = S_data_ram_size[SW-1:0];
                end
            end
            if ((w ? S_oe_ram[0] : S_we_ram[0]) | S_oe_ram[1] | S_we_ram[1] | (|S_addr_ram[2*AW-1:AW]) |
                (|S_Wdata_ram[2*DW-1:DW]) | (|S_data_ram_size[2*SW-1:SW])) bad = 1;
            if (rsp_valid) begin
                pulses++;
                if (lat == 0) begin lat = k; err = rsp_err; rd = rsp_rdata; end
            end
            Sout_DataRdy[0] = act && en == rdy_at;
            Sout_Rdata_ram[DW-1:0] = Sout_DataRdy[0] ? srd : '0;
            @(negedge clock);
        end
        Sout_DataRdy = '0;
    endtask

    // Starts a run; done_at = cycle index raising done_port (0 = RUN_START cycle, -1 = never).
    task automatic do_run(input int done_at, output int starts, output int dpulses, output logic err,
                          output logic [CW-1:0] cyc, output int dk);
        starts = 0; dpulses = 0; err = 0; cyc = '0; dk = -1;
        run_valid = 1;
        @(negedge clock);
        run_valid = 0;
        for (int k = 0; k <= 30; k++) begin
            starts += int'(start_port);
            if (run_done) begin
                dpulses++;
                if (dk < 0) begin dk = k; err = run_err; cyc = run_cycles; end
            end
            done_port = (k == done_at);
            @(negedge clock);
        end
        done_port = 0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
        checks++; if ({rsp_valid, start_port, run_done, S_oe_ram, S_we_ram} !== 7'd0) begin errors++;
            $display("FAIL reset_outs got %b want 0", {rsp_valid, start_port, run_done, S_oe_ram, S_we_ram}); end
        checks++; if (run_cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", run_cycles); end
        reset = 1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got %b want 0", cmd_ready); end
        @(negedge clock);
        checks++; if ({cmd_ready, run_ready} !== 2'b11) begin errors++; $display("FAIL release_ready got %b want 11", {cmd_ready, run_ready}); end
    endtask

    task automatic test_write_read;
        int en, lat, p; logic err, bad; logic [DW-1:0] rd, wds; logic [AW-1:0] as; logic [SW-1:0] ss;
        do_cmd(1, 9'h010, 64'hDEAD_BEEF, 7'd32, 2, 64'h0, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (en !== 2) begin errors++; $display("FAIL wr_en_cycles got %0d want 2", en); end
        checks++; if (lat !== 3 || p !== 1) begin errors++; $display("FAIL wr_rsp got lat %0d pulses %0d want 3 1", lat, p); end
        checks++; if (err !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL wr_err_rdata got %b %h want 0 0", err, rd); end
        checks++; if (as !== 9'h010 || wds !== 64'hDEAD_BEEF || ss !== 7'd32) begin errors++;
            $display("FAIL wr_bus got %h %h %0d want 010 deadbeef 32", as, wds, ss); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wr_other_fields got %b want 0", bad); end
        do_cmd(0, 9'h010, 64'h0, 7'd32, 2, 64'hFFFF_FFFF_DEAD_BEEF, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (rd !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL rd32_data got %h want deadbeef", rd); end
        checks++; if (en !== 2 || err !== 1'b0 || bad !== 1'b0) begin errors++; $display("FAIL rd32_ctl got %0d %b %b want 2 0 0", en, err, bad); end
        do_cmd(0, 9'h1FF, 64'h0, 7'd8, 1, 64'h1122_3344_5566_7788, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (rd !== 64'h88 || lat !== 2 || as !== 9'h1FF) begin errors++; $display("FAIL rd8 got %h lat %0d addr %h want 88 2 1ff", rd, lat, as); end
        do_cmd(0, 9'h020, 64'h0, 7'd16, 3, 64'h1122_3344_5566_7788, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (rd !== 64'h7788 || en !== 3) begin errors++; $display("FAIL rd16 got %h en %0d want 7788 3", rd, en); end
        do_cmd(0, 9'h008, 64'h0, 7'd64, 1, 64'h1122_3344_5566_7788, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd64 got %h want 1122334455667788", rd); end
    endtask

    task automatic test_illegal_size;
        int en, lat, p; logic err, bad; logic [DW-1:0] rd, wds; logic [AW-1:0] as; logic [SW-1:0] ss;
        do_cmd(1, 9'h004, 64'h55, 7'd12, 1, 64'h0, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (lat !== 1 || p !== 1 || err !== 1'b1) begin errors++; $display("FAIL illegal_rsp got lat %0d pulses %0d err %b want 1 1 1", lat, p, err); end
        checks++; if (en !== 0 || bad !== 1'b0) begin errors++; $display("FAIL illegal_bus got en %0d bad %b want 0 0", en, bad); end
    endtask

    task automatic test_mem_timeout;
        int en, lat, p; logic err, bad; logic [DW-1:0] rd, wds; logic [AW-1:0] as; logic [SW-1:0] ss;
        do_cmd(0, 9'h030, 64'h0, 7'd64, 0, 64'h0, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (en !== 255 || lat !== 256) begin errors++; $display("FAIL timeout_len got en %0d lat %0d want 255 256", en, lat); end
        checks++; if (err !== 1'b1 || rd !== 64'h0 || p !== 1) begin errors++; $display("FAIL timeout_rsp got %b %h %0d want 1 0 1", err, rd, p); end
        do_cmd(0, 9'h030, 64'h0, 7'd64, 255, 64'hABCD, en, lat, p, err, rd, as, wds, ss, bad);
        checks++; if (err !== 1'b0 || rd !== 64'hABCD || en !== 255) begin errors++; $display("FAIL rdy_at_255 got %b %h %0d want 0 abcd 255", err, rd, en); end
    endtask

    task automatic test_run;
        int st, dp, dk; logic err; logic [CW-1:0] cyc;
        do_run(10, st, dp, err, cyc, dk);
        checks++; if (st !== 1 || dp !== 1) begin errors++; $display("FAIL run_pulses got start %0d done %0d want 1 1", st, dp); end
        checks++; if (cyc !== 32'd10 || err !== 1'b0 || dk !== 11) begin errors++; $display("FAIL run_cycles got %0d err %b at %0d want 10 0 11", cyc, err, dk); end
        checks++; if (run_cycles !== 32'd10 || cmd_ready !== 1'b1) begin errors++; $display("FAIL run_hold got %0d ready %b want 10 1", run_cycles, cmd_ready); end
        do_run(0, st, dp, err, cyc, dk);
        checks++; if (cyc !== 32'd1 || dk !== 1 || err !== 1'b0) begin errors++; $display("FAIL run_done_at_start got %0d at %0d err %b want 1 1 0", cyc, dk, err); end
        do_run(-1, st, dp, err, cyc, dk);
        checks++; if (cyc !== 32'd16 || err !== 1'b1 || dk !== 17 || dp !== 1) begin errors++;
            $display("FAIL run_watchdog got %0d err %b at %0d pulses %0d want 16 1 17 1", cyc, err, dk, dp); end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1; run_valid = 1; cmd_write = 1; cmd_addr = 9'h040; cmd_wdata = 64'h77; cmd_size = 7'd8;
        @(negedge clock);
        cmd_valid = 0;
        checks++; if (S_we_ram[0] !== 1'b1 || start_port !== 1'b0) begin errors++; $display("FAIL prio_cmd_first got we %b start %b want 1 0", S_we_ram[0], start_port); end
        Sout_DataRdy[0] = 1;
        @(negedge clock);
        Sout_DataRdy[0] = 0;
        checks++; if (rsp_valid !== 1'b1 || start_port !== 1'b0) begin errors++; $display("FAIL prio_rsp got rsp %b start %b want 1 0", rsp_valid, start_port); end
        @(negedge clock);
        @(negedge clock);
        run_valid = 0;
        checks++; if (start_port !== 1'b1) begin errors++; $display("FAIL prio_run_after got start %b want 1", start_port); end
        done_port = 1;
        @(negedge clock);
        done_port = 0;
        checks++; if (run_done !== 1'b1 || run_cycles !== 32'd1) begin errors++; $display("FAIL prio_run_done got %b %0d want 1 1", run_done, run_cycles); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_access;
        int p = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 9'h050; cmd_size = 7'd32;
        @(negedge clock);
        cmd_valid = 0;
        repeat (2) @(negedge clock);
        checks++; if (S_oe_ram[0] !== 1'b1) begin errors++; $display("FAIL mid_oe_before got %b want 1", S_oe_ram[0]); end
        #2 reset = 0;
        #1;
        checks++; if ({S_oe_ram, S_we_ram, rsp_valid, cmd_ready} !== 6'd0) begin errors++;
            $display("FAIL mid_async_drop got %b want 0", {S_oe_ram, S_we_ram, rsp_valid, cmd_ready}); end
        @(negedge clock);
        reset = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            p += int'(rsp_valid);
        end
        checks++; if (p !== 0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release got pulses %0d ready %b want 0 1", p, cmd_ready); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_illegal_size;
        test_mem_timeout;
        test_run;
        test_back_to_back;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
